// File: rtl/inverter_1bit.sv
// Conditional 1-bit inverter with a zero-latency XOR output, plus a registered
// copy, a valid flag and a saturating count of accepted inversion samples.
module inverter_1bit #(
    parameter int   CNT_W = 8,
    parameter logic RST_Y = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             inv_signal,
    input  logic             in_valid,
    output logic             y,
    output logic             y_q,
    output logic             y_q_valid,
    output logic [CNT_W-1:0] inv_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic             y_s;
    logic             y_q_r;
    logic             y_q_valid_r;
    logic [CNT_W-1:0] inv_count_r;
    logic             y_q_next_s;
    logic [CNT_W-1:0] inv_count_next_s;

    // Polarity correction: no clock and no reset on this path.
    assign y_s = a ^ inv_signal;
    assign y   = y_s;

    // Next-state for the held output and the saturating inversion counter.
    always_comb begin
        y_q_next_s       = y_q_r;
        inv_count_next_s = inv_count_r;
        if (in_valid == 1'b1) begin
            y_q_next_s = y_s;
            if ((inv_signal == 1'b1) && (inv_count_r != CNT_MAX)) begin
                inv_count_next_s = inv_count_r + CNT_ONE;
            end else begin
                inv_count_next_s = inv_count_r;
            end
        end else begin
            y_q_next_s       = y_q_r;
            inv_count_next_s = inv_count_r;
        end
    end

    // Output, valid and counter registers; cleared immediately by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r       <= RST_Y;
            y_q_valid_r <= 1'b0;
            inv_count_r <= CNT_ZERO;
        end else begin
            y_q_r       <= y_q_next_s;
            y_q_valid_r <= in_valid;
            inv_count_r <= inv_count_next_s;
        end
    end

    assign y_q       = y_q_r;
    assign y_q_valid = y_q_valid_r;
    assign inv_count = inv_count_r;

endmodule

// File: tb/tb_inverter_1bit.sv
// Randomised self-checking bench for inverter_1bit against a behavioural model
// (result = a xor inv; count = min(count + 1, 2^CNT_W - 1)).
module tb_inverter_1bit;

    localparam int   CNT_W = 2;
    localparam logic RST_Y = 1'b0;
    localparam int   CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic             a;
    logic             inv_signal;
    logic             in_valid;
    logic             y;
    logic             y_q;
    logic             y_q_valid;
    logic [CNT_W-1:0] inv_count;

    int n_checks;
    int n_fails;

    // Reference state, updated from the behavioural rules on every rising edge.
    logic m_yq;
    logic m_valid;
    int   m_cnt;

    inverter_1bit #(.CNT_W(CNT_W), .RST_Y(RST_Y)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .inv_signal (inv_signal),
        .in_valid   (in_valid),
        .y          (y),
        .y_q        (y_q),
        .y_q_valid  (y_q_valid),
        .inv_count  (inv_count)
    );

    // Gated free-running clock so the combinational test can run with clk idle.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_yq    = RST_Y;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    // Applies one sample, advances to just after the next rising edge, updates the model.
    task automatic cycle(input logic v, input logic av, input logic iv);
        in_valid   = v;
        a          = av;
        inv_signal = iv;
        @(posedge clk);
        m_valid = v;
        if (v) begin
            m_yq = av ^ iv;
            if (iv && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb();
        logic [1:0] pat;
        logic exp_y;
        clk_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pat = 2'(i);
            a = pat[0];
            inv_signal = pat[1];
            #10;
            exp_y = (i == 1 || i == 2) ? 1'b1 : 1'b0;
            n_checks++;
            if (y !== exp_y) begin
                n_fails++;
                $display("FAIL comb_truth a=%b inv=%b: y=%b required %b", a, inv_signal, y, exp_y);
            end
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (y_q !== RST_Y || y_q_valid !== 1'b0 || inv_count !== '0) begin
            n_fails++;
            $display("FAIL reset_state: y_q=%b valid=%b cnt=%0d required %b 0 0", y_q, y_q_valid, inv_count, RST_Y);
        end
    endtask

    task automatic test_latency();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (y_q !== 1'b0 || y_q_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL latency_11: y_q=%b valid=%b required 0 1", y_q, y_q_valid);
        end
        cycle(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (y_q !== 1'b1 || y_q_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL latency_10: y_q=%b valid=%b required 1 1", y_q, y_q_valid);
        end
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (y_q !== 1'b1 || y_q_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL hold_invalid: y_q=%b valid=%b required 1 0", y_q, y_q_valid);
        end
    endtask

    task automatic test_counter();
        int exp_seq [5] = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'($urandom_range(1)), 1'b1);
            n_checks++;
            if (inv_count !== CNT_W'(exp_seq[i])) begin
                n_fails++;
                $display("FAIL counter_sat step %0d: cnt=%0d required %0d", i, inv_count, exp_seq[i]);
            end
        end
        cycle(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (inv_count !== CNT_W'(3)) begin
            n_fails++;
            $display("FAIL counter_hold_inv0: cnt=%0d required 3", inv_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (y_q !== 1'b1 || inv_count !== CNT_W'(2)) begin
            n_fails++;
            $display("FAIL async_precond: y_q=%b cnt=%0d required 1 2", y_q, inv_count);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        a = 1'b1;
        inv_signal = 1'b0;
        #1;
        n_checks++;
        if (y_q !== RST_Y || y_q_valid !== 1'b0 || inv_count !== '0) begin
            n_fails++;
            $display("FAIL async_clear: y_q=%b valid=%b cnt=%0d required %b 0 0", y_q, y_q_valid, inv_count, RST_Y);
        end
        n_checks++;
        if (y !== 1'b1) begin
            n_fails++;
            $display("FAIL comb_in_reset: y=%b required 1", y);
        end
    endtask

    task automatic test_release();
        in_valid = 1'b1;
        a = 1'b0;
        inv_signal = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (y_q !== RST_Y || y_q_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL no_capture_in_reset: y_q=%b valid=%b required %b 0", y_q, y_q_valid, RST_Y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (y_q !== RST_Y || y_q_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL capture_before_edge: y_q=%b valid=%b required %b 0", y_q, y_q_valid, RST_Y);
        end
        cycle(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (y_q !== 1'b1 || y_q_valid !== 1'b1 || inv_count !== CNT_W'(1)) begin
            n_fails++;
            $display("FAIL release_first_capture: y_q=%b valid=%b cnt=%0d required 1 1 1", y_q, y_q_valid, inv_count);
        end
    endtask

    // Random traffic; gaps=1 forces strictly alternating in_valid.
    task automatic run_random(input int n, input bit gaps);
        logic v, av, iv;
        for (int i = 0; i < n; i++) begin
            v  = gaps ? ((i % 2) == 0) : 1'($urandom_range(1));
            av = 1'($urandom_range(1));
            iv = 1'($urandom_range(1));
            cycle(v, av, iv);
            n_checks++;
            if (y_q !== m_yq || y_q_valid !== m_valid || inv_count !== CNT_W'(m_cnt)) begin
                n_fails++;
                $display("FAIL %s cycle %0d: y_q=%b valid=%b cnt=%0d required %b %b %0d",
                         gaps ? "gaps" : "random", i, y_q, y_q_valid, inv_count, m_yq, m_valid, m_cnt);
            end
            n_checks++;
            if (y !== (av ^ iv)) begin
                n_fails++;
                $display("FAIL %s_comb cycle %0d: y=%b required %b", gaps ? "gaps" : "random", i, y, av ^ iv);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        run_random(6, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
            n_checks++;
            if (y_q_valid !== 1'b1 || y_q !== m_yq || inv_count !== CNT_W'(m_cnt)) begin
                n_fails++;
                $display("FAIL back_to_back %0d: y_q=%b valid=%b cnt=%0d required %b 1 %0d",
                         i, y_q, y_q_valid, inv_count, m_yq, m_cnt);
            end
        end
        run_random(200, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        clk        = 1'b0;
        clk_en     = 1'b0;
        rst_n      = 1'b0;
        a          = 1'b0;
        inv_signal = 1'b0;
        in_valid   = 1'b0;
        model_reset();
        test_comb();
        test_reset();
        test_latency();
        test_counter();
        test_async_reset();
        test_release();
        test_gaps();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/inverter_1bit.md
Name: inverter_1bit

Overview:
Conditional 1-bit inverter: the output equals the input, or its complement when the invert control is high (y = a XOR inv_signal).
- The combinational output has zero latency. It is the primary function and is available without any clock edge.
- A registered copy, a valid flag and a saturating inversion counter are provided for pipelined consumers and debug visibility.
- The block sits in datapath polarity-correction logic, e.g. selectable-polarity signal lanes.

Parameters:
CNT_W, 8, width of the saturating inversion-event counter (legal range 1..32)
RST_Y, 1'b0, reset value of the registered output y_q

Ports:
clk  input  1  rising-edge clock for registered outputs
rst_n  input  1  asynchronous active-low reset
a  input  1  data input
inv_signal  input  1  invert control; 1 = output complement of a, 0 = pass a
in_valid  input  1  qualifies a/inv_signal for the registered path and counter
y  output  1  combinational result a ^ inv_signal
y_q  output  1  registered result
y_q_valid  output  1  high one cycle after an accepted in_valid
inv_count  output  CNT_W  number of accepted samples with inv_signal=1, saturating

Behaviour:
Clock and reset:
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.
- All flops clear immediately when rst_n=0, independent of clk.

Combinational path:
- y = a ^ inv_signal at all times, including during reset.
- No clock involvement on this path.
- Truth table: (a,inv) 00->0, 10->1, 01->1, 11->0.
- X on either input propagates as X on y; no masking.

Registered path:
- Reset values: y_q = RST_Y, y_q_valid = 0, inv_count = 0.
- On each rising clk with rst_n=1:
  - y_valid_q <= in_valid.
  - If in_valid=1, y_q <= a ^ inv_signal; otherwise y_q holds its previous value.
- Latency is exactly 1 cycle from an accepted sample to y_q/y_q_valid.
- There is no backpressure: every in_valid=1 cycle is accepted.

Counter:
- On a rising clk with in_valid=1 and inv_signal=1, inv_count increments by 1.
- It saturates at 2^CNT_W-1 and never wraps.
- It holds when in_valid=0 or inv_signal=0.

Boundary conditions:
- Reset asserted mid-stream: y_q, y_q_valid and inv_count clear asynchronously; y keeps tracking the inputs.
- Reset release: the first capture occurs on the first rising clk after rst_n goes high.
- Back-to-back valid samples: each is captured; y_q_valid stays high continuously.
- Counter at maximum with a further invert sample: the value holds at 2^CNT_W-1.

Decomposition:
- No shared package is needed: no typedefs; CNT_W and RST_Y are local parameters of the block.
- A single flat module. The combinational XOR, output register and counter are small enough that sub-modules add nothing.
- Optionally the saturating counter may be a sub-module, sat_counter, if one already exists in the library.

Test Plan:
- Combinational truth table: with clk idle, drive (a,inv) = 00, 10, 01, 11, holding each for 10 ns -> y = 0, 1, 1, 0 respectively, with no clock needed.
- Registered latency: reset, then in_valid=1 with a=1, inv=1 for one cycle -> y_q=0 and y_q_valid=1 on the next edge; with a=1, inv=0 -> y_q=1 one cycle later; with in_valid=0 -> y_q holds and y_q_valid=0.
- Counter: CNT_W=2; apply 5 consecutive valid samples with inv=1 -> inv_count goes 1, 2, 3, 3, 3. A sample with inv=0 leaves the count unchanged.
- Asynchronous reset: assert rst_n=0 between clock edges while y_q=1 and inv_count=2 -> y_q=RST_Y, y_q_valid=0 and inv_count=0 immediately. Meanwhile y still equals a^inv, e.g. a=1, inv=0 gives y=1.
- Reset release: deassert rst_n, then present a valid sample (a=0, inv=1) -> y_q=1 one cycle after it; no capture before the first post-release edge.
- Gaps: alternate in_valid 1/0 over 6 cycles with random a/inv -> y_q updates only on valid cycles; y_q_valid pulses with 1-cycle delay.
